// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared constants and types for the AES-128 key schedule.
//   NR     : number of rounds (AES-128 only)
//   KEY_W  : cipher key / round key width
//   EXP_W  : width of the packed expanded key, one 128-bit slot per round key
//   RCON   : round constants, indexed by round number 1..10 (0 and 11..15 unused)
//   state_t: key expansion FSM state
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int NR    = 10;
    localparam int KEY_W = 128;
    localparam int EXP_W = KEY_W * (NR + 1);

    // Padded to 16 entries so any 4-bit round counter indexes a defined entry.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box for one byte. The multiplicative inverse in
// GF(2^8) (modulus x^8+x^4+x^3+x+1) is formed as x^254, followed by the AES
// affine transform. Shared by the key schedule and the SubBytes stage.
// Ports:
//   i_byte : input byte
//   o_byte : substituted byte
// ---------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 = product of x^(2^k) for k=1..7; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] s;
        logic [7:0] r;
        s = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    logic [7:0] w_inv;

    always_comb begin
        w_inv  = gf_inv(i_byte);
        // b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
        o_byte = w_inv
               ^ {w_inv[6:0], w_inv[7]}
               ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]}
               ^ {w_inv[3:0], w_inv[7:4]}
               ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_expansion.sv
// ---------------------------------------------------------------------------
// aes_key_expansion
// Iterative AES-128 key schedule: one round key per clock after start is
// accepted, key_valid rises 10 cycles after the accepting edge. The packed
// schedule is held until the next accepted start.
// Ports:
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   start        : expansion request, honoured only when not busy
//   key_in       : cipher key (byte 0 at [127:120]), sampled on accept
//   busy         : expansion in progress
//   key_valid    : expanded_key holds a complete schedule
//   expanded_key : round key r at [128*r+127 : 128*r], word 0 at the MSBs
//   zeroize      : (only with KEY_EXP_ZEROIZE_EN) synchronous clear, has
//                  priority over start and over a running expansion
// Optional feature macro: KEY_EXP_ZEROIZE_EN
// ---------------------------------------------------------------------------
module aes_key_expansion
    import aes_pkg::*;
#(
    parameter  int NR    = aes_pkg::NR,
    localparam int EXP_W = 128 * (NR + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [127:0]     key_in,
    output logic             busy,
    output logic             key_valid,
    output logic [EXP_W-1:0] expanded_key
`ifdef KEY_EXP_ZEROIZE_EN
    ,
    input  logic             zeroize
`endif
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [KEY_W-1:0] r_rk [0:NR];
    logic             r_busy;
    logic             r_valid;

    logic             w_zero;
    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic             w_illegal;
    logic [KEY_W-1:0] w_prev;
    logic [31:0]      w_rot;
    logic [31:0]      w_sub;
    logic [31:0]      w_t;
    logic [31:0]      w_w0;
    logic [31:0]      w_w1;
    logic [31:0]      w_w2;
    logic [31:0]      w_w3;

`ifdef KEY_EXP_ZEROIZE_EN
    assign w_zero = zeroize;
`else
    assign w_zero = 1'b0;
`endif

    // ---- round function: round key [r_cnt] from round key [r_cnt-1] ----
    assign w_prev = r_rk[r_cnt - 4'd1];
    assign w_rot  = {w_prev[23:0], w_prev[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign w_t  = w_sub ^ {RCON[r_cnt], 24'h000000};
    assign w_w0 = w_prev[127:96] ^ w_t;
    assign w_w1 = w_prev[95:64]  ^ w_w0;
    assign w_w2 = w_prev[63:32]  ^ w_w1;
    assign w_w3 = w_prev[31:0]   ^ w_w2;

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start)  w_state_nxt = ST_EXPAND;
            ST_EXPAND:        if (w_last) w_state_nxt = ST_DONE;
            default:                      w_state_nxt = ST_IDLE;
        endcase
        if (w_zero) w_state_nxt = ST_IDLE;
    end

    // ---- FSM: decoded controls ----
    always_comb begin
        w_illegal = !(r_state == ST_IDLE || r_state == ST_EXPAND || r_state == ST_DONE);
        w_accept  = !w_zero && start && (r_state == ST_IDLE || r_state == ST_DONE);
        w_step    = !w_zero && (r_state == ST_EXPAND);
        w_last    = w_step && (r_cnt == LAST_RND);
    end

    // ---- registered schedule, counter and handshake outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
        end else if (w_zero) begin
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
        end else if (w_accept) begin
            r_rk[0] <= key_in;
            r_cnt   <= 4'd1;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
        end else if (w_step) begin
            r_rk[r_cnt] <= {w_w0, w_w1, w_w2, w_w3};
            if (w_last) begin
                r_busy  <= 1'b0;
                r_valid <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end else if (w_illegal) begin
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end
    end

    for (genvar g = 0; g <= NR; g++) begin : g_pack
        assign expanded_key[128*g +: 128] = r_rk[g];
    end

    assign busy      = r_busy;
    assign key_valid = r_valid;

endmodule

// File: tb/tb_aes_key_expansion.sv
`timescale 1ns/1ps
module tb_aes_key_expansion;

    localparam int EXP_W = 1408;

    localparam logic [127:0] KEY_A1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_ZERO  = 128'h0;
    localparam logic [127:0] A1_SLOT1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_SLOT10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_SLOT1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_SLOT10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b1;
    logic             start  = 1'b0;
    logic [127:0]     key_in = '0;
    logic             busy;
    logic             key_valid;
    logic [EXP_W-1:0] expanded_key;
`ifdef KEY_EXP_ZEROIZE_EN
    logic             zeroize = 1'b0;
`endif

    aes_key_expansion dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .key_in       (key_in),
        .busy         (busy),
        .key_valid    (key_valid),
        .expanded_key (expanded_key)
`ifdef KEY_EXP_ZEROIZE_EN
        ,
        .zeroize      (zeroize)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_exp(input string nm, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            for (int r = 0; r < 11; r++) begin
                if (act[128*r +: 128] !== exp[128*r +: 128]) begin
                    $display("FAIL %s slot %0d: got %h expected %h (t=%0t)",
                             nm, r, act[128*r +: 128], exp[128*r +: 128], $time);
                    break;
                end
            end
        end
    endtask

    // ---- reference model: textbook FIPS-197 word-recurrence key schedule ----
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        inv = 8'h00;
        c   = 8'h63;
        for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
        return s;
    endfunction

    function automatic logic [EXP_W-1:0] sched(input logic [127:0] k);
        logic [31:0]      w [0:43];
        logic [31:0]      t;
        logic [7:0]       rc;
        logic [EXP_W-1:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
                t[31:24] = t[31:24] ^ rc;
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        o = '0;
        for (int r = 0; r < 11; r++) o[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return o;
    endfunction

    // Cycle view of the handshake: slot 0 on accept, one slot per clock after.
    logic             m_busy  = 1'b0;
    logic             m_valid = 1'b0;
    int               m_cnt   = 0;
    logic [EXP_W-1:0] m_exp   = '0;
    logic [EXP_W-1:0] m_sched = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_valid = 1'b0; m_cnt = 0; m_exp = '0;
        end
`ifdef KEY_EXP_ZEROIZE_EN
        else if (zeroize) begin
            m_busy = 1'b0; m_valid = 1'b0; m_cnt = 0; m_exp = '0;
        end
`endif
        else if (start && !m_busy) begin
            m_sched       = sched(key_in);
            m_exp[127:0]  = key_in;
            m_cnt         = 1;
            m_busy        = 1'b1;
            m_valid       = 1'b0;
        end else if (m_busy) begin
            m_exp[128*m_cnt +: 128] = m_sched[128*m_cnt +: 128];
            if (m_cnt == 10) begin
                m_busy  = 1'b0;
                m_valid = 1'b1;
            end else begin
                m_cnt++;
            end
        end
    end

    bit chk_on = 1'b0;
    always @(posedge clk) begin
        #2;
        if (chk_on) begin
            chk("busy", 128'(busy), 128'(m_busy));
            chk("key_valid", 128'(key_valid), 128'(m_valid));
            chk_exp("expanded_key", expanded_key, m_exp);
        end
    end

    // Start an expansion, optionally re-pulse start with kx at cycles pa/pb,
    // and return the number of cycles from the accepting edge to key_valid.
    task automatic run_exp(input logic [127:0] k, input int pa, input int pb,
                           input logic [127:0] kx, output int lat);
        @(negedge clk);
        start  = 1'b1;
        key_in = k;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("accept_busy", 128'(busy), 128'(1));
        chk("accept_valid_low", 128'(key_valid), 128'(0));
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            if (n == pa || n == pb) begin
                start  = 1'b1;
                key_in = kx;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (key_valid) begin
                lat = n;
                break;
            end
        end
        chk("latency", 128'(lat), 128'(10));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [EXP_W-1:0] s;

        // model pins against published values
        chk("ref_sbox_00", 128'(sbox_ref(8'h00)), 128'h63);
        chk("ref_sbox_53", 128'(sbox_ref(8'h53)), 128'hed);
        s = sched(KEY_A1);
        chk("ref_a1_slot1", s[128 +: 128], A1_SLOT1);
        chk("ref_a1_slot10", s[1280 +: 128], A1_SLOT10);
        s = sched(KEY_ZERO);
        chk("ref_zero_slot1", s[128 +: 128], Z_SLOT1);
        chk("ref_zero_slot10", s[1280 +: 128], Z_SLOT10);

        // reset
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_valid", 128'(key_valid), 128'(0));
        chk_exp("reset_expanded", expanded_key, '0);
        chk_on = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // FIPS-197 A.1 key
        run_exp(KEY_A1, 0, 0, KEY_ZERO, lat);
        chk("a1_slot0", expanded_key[127:0], KEY_A1);
        chk("a1_slot1", expanded_key[128 +: 128], A1_SLOT1);
        chk("a1_slot10", expanded_key[1280 +: 128], A1_SLOT10);
        repeat (3) @(posedge clk);

        // back-to-back restart from DONE with the zero key
        run_exp(KEY_ZERO, 0, 0, KEY_ZERO, lat);
        chk("zero_slot1", expanded_key[128 +: 128], Z_SLOT1);
        chk("zero_slot10", expanded_key[1280 +: 128], Z_SLOT10);
        repeat (2) @(posedge clk);

        // start re-pulsed at cycles 3 and 7 with another key: ignored
        run_exp(KEY_A1, 3, 7, KEY_ZERO, lat);
        chk("ignore_slot1", expanded_key[128 +: 128], A1_SLOT1);
        chk("ignore_slot10", expanded_key[1280 +: 128], A1_SLOT10);
        repeat (2) @(posedge clk);

        // reset asserted at cycle 5 of an expansion
        @(negedge clk);
        start  = 1'b1;
        key_in = KEY_ZERO;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_valid", 128'(key_valid), 128'(0));
        chk_exp("midrst_expanded", expanded_key, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_exp(KEY_A1, 0, 0, KEY_ZERO, lat);
        chk("after_rst_slot10", expanded_key[1280 +: 128], A1_SLOT10);

`ifdef KEY_EXP_ZEROIZE_EN
        // zeroize in DONE
        @(negedge clk);
        zeroize = 1'b1;
        @(posedge clk);
        #1 zeroize = 1'b0;
        chk("zdone_busy", 128'(busy), 128'(0));
        chk("zdone_valid", 128'(key_valid), 128'(0));
        chk_exp("zdone_expanded", expanded_key, '0);

        // zeroize mid-expansion
        @(negedge clk);
        start  = 1'b1;
        key_in = KEY_A1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        zeroize = 1'b1;
        @(posedge clk);
        #1 zeroize = 1'b0;
        chk("zmid_busy", 128'(busy), 128'(0));
        chk("zmid_valid", 128'(key_valid), 128'(0));
        chk_exp("zmid_expanded", expanded_key, '0);

        // zeroize together with start: no expansion
        @(negedge clk);
        zeroize = 1'b1;
        start   = 1'b1;
        key_in  = KEY_A1;
        @(posedge clk);
        #1;
        zeroize = 1'b0;
        start   = 1'b0;
        chk("zstart_busy", 128'(busy), 128'(0));
        @(posedge clk);
        #1;
        chk("zstart_busy_next", 128'(busy), 128'(0));
        chk_exp("zstart_expanded", expanded_key, '0);
`endif

        repeat (3) @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_key_expansion.md
Name: aes_key_expansion

Overview:
- Iterative AES-128 key schedule. Takes a 128-bit cipher key and produces all 11 round keys, one per clock.
- Output is packed into the 1408-bit expanded_key bus consumed by the add-round-key stages, directly upstream of them.
- Uses a start/busy/key_valid handshake. The expanded key is held stable until the next accepted start.

Parameters:
- NR, 10: number of AES rounds. Only 10 (AES-128) is supported.
- EXP_W, 1408: expanded key width, equal to 128*(NR+1). Derived value; never overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to expand key_in; honoured only when busy=0
- key_in  in  128  cipher key, sampled on the edge that accepts start; byte 0 at [127:120]
- busy  out  1  high while expansion is in progress
- key_valid  out  1  high while expanded_key holds a complete schedule
- expanded_key  out  1408  round key r at [128*r+127 : 128*r]; within a round key, word 0 at the MSBs

Behaviour:
- All outputs are registered.
- Reset (async assert, sync release): state=IDLE, round counter=0, expanded_key=0, busy=0, key_valid=0.
- FSM states: IDLE, EXPAND, DONE.
- IDLE or DONE, with start=1 at edge E0:
  - round key 0 <= key_in
  - counter <= 1, state <= EXPAND
  - busy <= 1, key_valid <= 0
- EXPAND, each edge: compute round key [counter] from round key [counter-1], in one combinational pass:
  - t = SubWord(RotWord(w3)) ^ {RCON[counter],24'h0}
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
  - Write the result into its slot, then counter++.
- On the edge that writes round key 10 (E10):
  - state <= DONE, busy <= 0, key_valid <= 1
  - Latency: key_valid is high after edge E10, i.e. 10 cycles after the accepting edge.
- RCON[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- start while busy=1: ignored. No queuing; the current expansion is unaffected.
- start in DONE: restarts. key_valid drops at the accepting edge and slots 1..10 are overwritten progressively.
- During EXPAND, unwritten slots keep stale contents. Consumers use expanded_key only while key_valid=1.
- Counter stays in 1..10 in EXPAND and never wraps. An illegal FSM state returns to IDLE.
- Reset asserted mid-expansion: immediate clear to reset values. No partial key survives.

Optional Feature:
- Macro: KEY_EXP_ZEROIZE_EN.
- Defined:
  - Adds input port zeroize (1 bit), sampled synchronously.
  - zeroize=1 at an edge clears expanded_key to 0, key_valid=0, busy=0, state=IDLE.
  - It has priority over start and over an in-progress expansion.
- Undefined: no zeroize port; the schedule is cleared only by rst_n.

Decomposition:
- Package aes_pkg holds:
  - NR, KEY_W=128, EXP_W
  - RCON table as a constant array
  - FSM state enum typedef
- Sub-module aes_sbox: combinational 8-bit forward S-box lookup, instantiated 4 times for SubWord.
- Kept separate so the SubBytes stage can reuse it.

Test Plan:
- FIPS-197 A.1 key, start pulse:
  - key_in=2b7e151628aed2a6abf7158809cf4f3c
  - key_valid rises exactly 10 cycles after the accepting edge
  - slot1=a0fafe1788542cb123a339392a6c7605
  - slot10=d014f9a8c9ee2589e13f0cc8b6630ca6
- All-zero key:
  - slot1=62636363626363636263636362636363
  - slot10=b4ef5bcb3e92e21123e951cf6f8f188e
- start re-pulsed at cycles 3 and 7 of an expansion with a different key_in: ignored; result matches the first key and timing is unchanged.
- Back-to-back: start in DONE with the zero key after the A.1 key:
  - key_valid drops on the accepting edge
  - zero-key schedule is valid 10 cycles later
- rst_n asserted at cycle 5 of an expansion:
  - outputs zero immediately
  - after release, a new start completes correctly
- With KEY_EXP_ZEROIZE_EN: zeroize in DONE and mid-EXPAND gives expanded_key=0, key_valid=0, busy=0 next cycle; zeroize with simultaneous start gives no expansion.
